// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU-sharing arbiter.
package alu_ctrl_pkg;

    localparam int   W_DEF  = 4;
    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]        i_req,
    input  logic [ptr_w(N)-1:0] i_ptr,
    output logic [N-1:0]        o_grant
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external add/sub ALU among N_REQ requesters; one operation in flight at a time.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int N_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_s,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W-1:0]       rsp_q,
    output logic               rsp_c,
    output logic               busy,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic               alu_s,
    input  logic [W-1:0]       alu_q,
    input  logic               alu_c
);

    localparam int PW = ptr_w(N_REQ);

    state_t           r_state, w_state_next;
    logic [PW-1:0]    r_ptr, r_grant_id;
    logic [W-1:0]     r_alu_a, r_alu_b, r_rsp_q;
    logic             r_alu_s, r_rsp_c;
    logic [N_REQ-1:0] r_rsp_valid;

    logic [N_REQ-1:0] w_grant;
    logic [PW-1:0]    w_grant_idx;
    logic             w_accept, w_rsp_done;
    logic [W-1:0]     w_a [N_REQ];
    logic [W-1:0]     w_b [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_a[gi] = req_a[gi*W +: W];
            assign w_b[gi] = req_b[gi*W +: W];
        end
    endgenerate

    rr_arbiter #(.N(N_REQ)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) w_grant_idx = PW'(i);
        end
    end

    assign w_accept   = (r_state == IDLE) && (|req_valid);
    assign w_rsp_done = (r_state == RESP) && rsp_ready[r_grant_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|req_valid) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready[r_grant_id]) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE) ? w_grant : '0;
        busy      = (r_state != IDLE);
    end

    // Operands stay put between operations so the ALU inputs never glitch to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_s     <= OP_SUB;
            r_rsp_q     <= '0;
            r_rsp_c     <= 1'b0;
            r_rsp_valid <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= w_a[w_grant_idx];
                r_alu_b    <= w_b[w_grant_idx];
                r_alu_s    <= req_s[w_grant_idx];
                r_grant_id <= w_grant_idx;
            end
            if (r_state == EXEC) begin
                r_rsp_q     <= alu_q;
                r_rsp_c     <= alu_c;
                r_rsp_valid <= N_REQ'(1) << r_grant_id;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= '0;
                r_ptr       <= (r_grant_id == PW'(N_REQ-1)) ? '0 : r_grant_id + PW'(1);
            end
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign rsp_q     = r_rsp_q;
    assign rsp_c     = r_rsp_c;
    assign rsp_valid = r_rsp_valid;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 4-bit add/subtract ALU between several requesters. Each requester issues an operation (two operands plus add/sub select) over a valid/ready handshake. A round-robin arbiter picks one requester, and the block drives the ALU from registered operands, captures the result and carry/borrow, and returns them to the winning requester over a second valid/ready handshake. The block sits between the requester logic and the ALU. The ALU itself stays outside this block and is reached through the alu_* ports.

## Interface
- W, 4, operand/result width; must equal the ALU width.
- N_REQ, 2, number of requesters; legal range 2..4.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  N_REQ  requester i has an operation pending.
- req_ready  output  N_REQ  one-hot; operation of requester i accepted this cycle.
- req_a  input  N_REQ*W  operand A; slice i belongs to requester i.
- req_b  input  N_REQ*W  operand B; slice i belongs to requester i.
- req_s  input  N_REQ  op select per requester: 1 = add, 0 = subtract (A-B).
- rsp_valid  output  N_REQ  one-hot; result for requester i is valid.
- rsp_ready  input  N_REQ  requester i takes the result.
- rsp_q  output  W  result, shared by all requesters.
- rsp_c  output  1  carry out for add, borrow out for subtract.
- busy  output  1  high whenever state is not IDLE.
- alu_a  output  W  registered operand A to the ALU.
- alu_b  output  W  registered operand B to the ALU.
- alu_s  output  1  registered op select to the ALU.
- alu_q  input  W  ALU result (combinational from alu_a/alu_b/alu_s).
- alu_c  input  1  ALU carry/borrow.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE**
  - If any req_valid is high, the arbiter grants requester g.
  - g is the first requester with req_valid high, searching from ptr upward and wrapping.
  - req_ready[g] is driven combinationally in the same cycle.
  - On that edge the block latches req_a[g], req_b[g] and req_s[g] into alu_a, alu_b and alu_s, stores g in grant_id, and moves to EXEC.
- **EXEC**
  - On the edge that leaves EXEC, the block samples alu_q into rsp_q and alu_c into rsp_c.
  - Next state is RESP.
- **RESP**
  - rsp_valid[grant_id] = 1. rsp_q and rsp_c are held stable.
  - When rsp_ready[grant_id] is high, the state returns to IDLE and ptr becomes (grant_id+1) mod N_REQ.
  - rsp_ready bits of other requesters are ignored.
- req_ready is all-zero outside IDLE.
- The block never issues a new ALU operation while a response is pending.
- alu_a, alu_b and alu_s hold their last values between operations; nothing redrives them to zero.
- Carry semantics follow the ALU exactly:
  - Add: rsp_q = (A+B) mod 2^W, rsp_c = carry out.
  - Subtract: rsp_q = (A-B) mod 2^W, rsp_c = 1 iff A < B (unsigned).
- Boundary rules:
  - **Simultaneous requests:** ptr decides the winner; losers keep req_valid high and wait.
  - **Single persistent requester:** it is served back-to-back; ptr still advances past it each time.
  - **Fairness:** with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0.
  - **req_valid withdrawn while not granted:** legal; the request is simply not considered.
  - **rsp_ready held low:** RESP lasts indefinitely, busy stays high, and no other request is accepted.
  - **Reset mid-operation:** the transaction in flight is discarded and no response is produced.

## Timing
- Reset values: state = IDLE, ptr = 0, grant_id = 0. alu_a, alu_b, alu_s, rsp_q and rsp_c = 0. req_ready, rsp_valid and busy = 0.
- Accept in cycle N (req_valid & req_ready) gives rsp_valid high from cycle N+2.
- If rsp_ready is already high in N+2, the next accept can occur in cycle N+3.
- Peak throughput is one operation per 3 cycles.
- req_ready depends combinationally on req_valid, state and ptr. rsp_valid, rsp_q and rsp_c are pure register outputs.
- The ALU path has one full cycle in EXEC: alu_* registered → ALU → rsp_q register.

## Structure
- Package alu_ctrl_pkg holds:
  - state enum state_t {IDLE, EXEC, RESP};
  - OP_ADD = 1'b1 and OP_SUB = 1'b0;
  - default width W_DEF = 4.
- Sub-module rr_arbiter is pure combinational. Inputs are the request vector and ptr; output is a one-hot grant.
- FSM, operand registers and result registers stay in alu_arbiter.

## Test plan
- **Reset values:** assert rst mid-EXEC → next cycle all outputs are 0 and state is IDLE; after release no rsp_valid appears.
- **Single add:** req0 A=4'h7, B=4'h3, s=1 → req_ready[0] in cycle N; rsp_valid[0] in N+2 with rsp_q=4'hA, rsp_c=0.
- **Add with carry and subtract with borrow:**
  - A=9, B=8, s=1 → rsp_q=4'h1, rsp_c=1.
  - A=3, B=5, s=0 → rsp_q=4'hE, rsp_c=1.
  - A=5, B=3, s=0 → rsp_q=4'h2, rsp_c=0.
- **Simultaneous requests, fairness:** req0 and req1 valid continuously from reset with rsp_ready=all-ones → grants 0,1,0,1, each result tagged to the correct requester.
- **Response backpressure:** rsp_ready[1]=0 for 5 cycles in RESP with req0 valid → rsp_valid[1], rsp_q and busy held, req_ready=0. Then rsp_ready[1]=1 → req0 accepted the following cycle.
- **Wrong-requester ready and withdrawal:** rsp_ready[0]=1 while rsp_valid[1] is high → ignored. req1 valid drops before grant → no grant to 1, no response.
